// File: rtl/uart_rxr_pkg.sv
// Shared definitions for the UART receiver: FSM states and frame constants.
package uart_rxr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // Counter value at which the start bit is re-checked (middle of the start bit).
    function automatic int half_bit(input int cpb);
        return (cpb - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rxr_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rxr.sv
// UART receiver: 8N1, MSB first, mid-bit sampling driven by a per-bit cycle counter.
module uart_rxr
    import uart_rxr_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_data_line,
    output logic       o_data_ready,
    output logic [7:0] o_data_byte_out
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx;
    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [CNT_W-1:0]     cyc_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 start_hit;
    logic                 bit_hit;
    logic                 stop_hit;
    logic                 cnt_clr;
    logic                 load_byte;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .d    (i_rx_data_line),
        .q    (rx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!rx) state_nxt = START;
            end
            START: begin
                // A start bit that is high again at its midpoint was only a glitch.
                if (start_hit) state_nxt = rx ? IDLE : DATA;
            end
            DATA: begin
                if (bit_hit && (bit_cnt == LAST_BIT)) state_nxt = STOP;
            end
            STOP: begin
                if (stop_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_hit = (state == START) && (cyc_cnt == HALF_CNT);
        bit_hit   = (state == DATA)  && (cyc_cnt == LAST_CNT);
        stop_hit  = (state == STOP)  && (cyc_cnt == LAST_CNT);
        cnt_clr   = (state == IDLE) || start_hit || bit_hit || stop_hit;
        load_byte = stop_hit && rx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            cyc_cnt <= cnt_clr ? '0 : cyc_cnt + 1'b1;
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (bit_hit && (bit_cnt != LAST_BIT)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_reg <= '0;
        end else if (bit_hit) begin
            shift_reg <= {shift_reg[DATA_BITS-2:0], rx};
        end
    end

    // A framing error simply skips the load, so the previous byte stays visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_ready    <= 1'b0;
            o_data_byte_out <= '0;
        end else begin
            o_data_ready <= load_byte;
            if (load_byte) o_data_byte_out <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rxr.sv
// Randomized bench for uart_rxr: frame-level reference model with an expected-byte scoreboard.
module tb_uart_rxr;
    import uart_rxr_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line10;
    logic       line16;
    logic       rdy10;
    logic       rdy16;
    logic [7:0] byte10;
    logic [7:0] byte16;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] b;
        int         t0;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_out  = 8'h00;
    logic       prev_rdy = 1'b0;
    int         pulses   = 0;

    int         cnt16  = 0;
    logic [7:0] last16 = 8'h00;
    int         lat16  = 0;
    int         t16    = 0;

    uart_rxr #(.CLKS_PER_BIT(10)) dut10 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rx_data_line (line10),
        .o_data_ready   (rdy10),
        .o_data_byte_out(byte10)
    );

    uart_rxr #(.CLKS_PER_BIT(16)) dut16 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rx_data_line (line16),
        .o_data_ready   (rdy16),
        .o_data_byte_out(byte16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard for the CLKS_PER_BIT=10 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_out  = 8'h00;
            prev_rdy = 1'b0;
        end else begin
            if (rdy10) begin
                exp_t it;
                int   lat;
                pulses++;
                check("double_pulse", prev_rdy, 1'b0);
                check("pulse_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    it  = exp_q.pop_front();
                    lat = cyc - it.t0;
                    check("data", byte10, it.b);
                    check($sformatf("latency_95_100_lat%0d", lat), (lat >= 95) && (lat <= 100), 1'b1);
                    exp_out = it.b;
                end
            end else begin
                check("hold", byte10, exp_out);
            end
            prev_rdy = rdy10;
        end
    end

    always @(negedge clk) begin
        if (rst_n && rdy16) begin
            cnt16++;
            last16 = byte16;
            lat16  = cyc - t16;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 1) line16 = v;
        else            line10 = v;
    endtask

    // Sends start, 8 data bits MSB first, stop. abort_slot >= 0 resets the DUTs midway through that bit.
    task automatic send_frame(input int which, input logic [7:0] b, input logic stop_bit, input int abort_slot);
        logic [9:0] bits;
        int         cpb;
        int         t0;
        bits = {1'b0, b, stop_bit};
        cpb  = (which == 1) ? 16 : 10;
        t0   = cyc;
        if (which == 1) t16 = cyc;
        for (int s = 0; s < 10; s++) begin
            drive(which, bits[9-s]);
            if (s == abort_slot) begin
                tick(cpb / 2);
                rst_n = 1'b0;
                #1;
                check("rst_mid_ready", rdy10, 1'b0);
                check("rst_mid_byte", byte10, 8'h00);
                check("rst_mid_state", 32'(dut10.state), 32'(IDLE));
                drive(which, 1'b1);
                tick(3);
                rst_n = 1'b1;
                return;
            end
            if (s == 9 && which == 0 && stop_bit) exp_q.push_back('{b, t0});
            tick(cpb);
        end
        drive(which, 1'b1);
    endtask

    initial begin
        int         p0;
        logic [7:0] b;
        logic       stop_ok;
        logic       prev_ok;
        int         gap;

        rst_n  = 1'b0;
        line10 = 1'b1;
        line16 = 1'b1;
        tick(3);
        check("reset_ready", rdy10, 1'b0);
        check("reset_byte", byte10, 8'h00);
        check("reset_state", 32'(dut10.state), 32'(IDLE));
        check("reset_ready16", rdy16, 1'b0);
        rst_n = 1'b1;
        tick(20);

        p0 = pulses;
        send_frame(0, 8'h7A, 1'b1, -1);
        tick(20);
        check("7A_pulses", pulses - p0, 1);
        check("7A_byte", byte10, 8'h7A);

        p0 = pulses;
        line10 = 1'b0;
        tick(3);
        line10 = 1'b1;
        tick(20);
        check("glitch_pulses", pulses - p0, 0);
        check("glitch_state", 32'(dut10.state), 32'(IDLE));
        check("glitch_byte", byte10, 8'h7A);

        p0 = pulses;
        send_frame(0, 8'hA5, 1'b0, -1);
        tick(15);
        check("ferr_pulses", pulses - p0, 0);
        check("ferr_byte", byte10, 8'h7A);
        send_frame(0, 8'h3C, 1'b1, -1);
        tick(10);
        check("3C_pulses", pulses - p0, 1);
        check("3C_byte", byte10, 8'h3C);

        p0 = pulses;
        send_frame(0, 8'h00, 1'b1, -1);
        send_frame(0, 8'hFF, 1'b1, -1);
        tick(10);
        check("b2b_pulses", pulses - p0, 2);
        check("b2b_byte", byte10, 8'hFF);

        p0 = pulses;
        send_frame(0, 8'h55, 1'b1, 4);
        tick(20);
        check("abort_pulses", pulses - p0, 0);
        check("abort_byte", byte10, 8'h00);
        check("abort_ready", rdy10, 1'b0);
        send_frame(0, 8'h81, 1'b1, -1);
        tick(10);
        check("81_pulses", pulses - p0, 1);
        check("81_byte", byte10, 8'h81);

        send_frame(1, 8'hC3, 1'b1, -1);
        tick(20);
        check("C3_pulses", cnt16, 1);
        check("C3_byte", last16, 8'hC3);
        check($sformatf("C3_latency_150_160_lat%0d", lat16), (lat16 >= 150) && (lat16 <= 160), 1'b1);

        prev_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b       = 8'($urandom_range(255));
            stop_ok = ($urandom_range(99) < 85);
            gap     = ($urandom_range(3) == 0) ? 0 : $urandom_range(20);
            if (!prev_ok) gap = gap + 12;
            tick(gap);
            if ($urandom_range(4) == 0) begin
                line10 = 1'b0;
                tick($urandom_range(4, 1));
                line10 = 1'b1;
                tick(15);
            end
            send_frame(0, b, stop_ok, -1);
            prev_ok = stop_ok;
        end
        tick(30);
        check("queue_empty", exp_q.size(), 0);
        check("final_ready", rdy10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rxr.md
UART_RXR -- requirements
Module: uart_rxr

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10, meaning i_clk cycles per serial bit; legal values are 4 or more.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_rx_data_line, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The block SHALL have port o_data_ready, output, 1 bit: one-cycle pulse when a valid byte is received.
REQ-006 The block SHALL have port o_data_byte_out, output, 8 bits: the last valid received byte.

Function
REQ-007 i_rx_data_line SHALL pass through a 2-flop synchronizer before use; all timing below is relative to the synchronized line.
REQ-008 Frame format SHALL be 1 start bit (0), 8 data bits MSB first, 1 stop bit (1), no parity; each bit lasts CLKS_PER_BIT clocks.
REQ-009 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-010 IDLE: bit counter cleared; a synchronized 0 SHALL move the FSM to START with the cycle counter at 0.
REQ-011 START: when the cycle counter reaches (CLKS_PER_BIT-1)/2 (integer division), the line SHALL be sampled. If 0, the FSM goes to DATA with the counter cleared. If 1, the event is a glitch and the FSM returns to IDLE.
REQ-012 DATA: when the cycle counter reaches CLKS_PER_BIT-1 (mid-bit), the line SHALL be sampled and shifted in from the LSB side (shift register <= {sr[6:0], bit}), and the counter cleared. After the 8th sample the FSM goes to STOP.
REQ-013 STOP: at counter CLKS_PER_BIT-1 the line SHALL be sampled. If 1, o_data_byte_out <= shift register and o_data_ready = 1 for exactly one clock. If 0 (framing error), there is no pulse and o_data_byte_out is unchanged. In both cases the FSM returns to IDLE.
REQ-014 After a STOP sample the FSM SHALL be in IDLE so that a start bit arriving immediately after the stop-bit midpoint is detected; back-to-back frames SHALL be received without loss.
REQ-015 o_data_byte_out SHALL hold its value between frames and change only in the o_data_ready cycle.
REQ-016 o_data_ready SHALL never be asserted for two consecutive cycles.
REQ-017 The cycle counter SHALL be $clog2(CLKS_PER_BIT) bits wide and the bit counter 3 bits wide; neither SHALL wrap outside the rules above.
REQ-018 Line activity during DATA/STOP SHALL affect only the samples at the sample points.

Reset
REQ-019 Asserting i_rst_n low SHALL immediately force: FSM to IDLE, counters 0, shift register 0x00, synchronizer flops 1, o_data_ready 0, o_data_byte_out 0x00.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no pulse. After release, the FSM SHALL wait in IDLE for the next falling edge, treating a line already low as a new start.

Structure
REQ-021 The state enumeration (IDLE, START, DATA, STOP) and frame constants (DATA_BITS = 8) SHALL live in shared package uart_rxr_pkg.
REQ-022 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff (parameterized reset value 1); everything else SHALL be in uart_rxr.

Verification
REQ-023 With CLKS_PER_BIT=10 and the line idle high for 20 clocks, sending 0x7A MSB first (line sequence 0,0,1,1,1,1,0,1,0,1, 10 clocks per bit) -> exactly one o_data_ready pulse, between 95 and 100 clocks after the start edge, with o_data_byte_out = 0x7A.
REQ-024 A low glitch of 3 clocks on an idle line -> no o_data_ready, FSM back in IDLE, o_data_byte_out unchanged.
REQ-025 A frame 0xA5 with the stop bit driven 0 -> no pulse and o_data_byte_out keeps its prior value; a following valid 0x3C -> pulse with 0x3C.
REQ-026 Back-to-back frames 0x00 then 0xFF with no idle gap -> two pulses, values 0x00 then 0xFF.
REQ-027 Reset asserted during data bit 4 of 0x55, then released -> no pulse, outputs 0x00/0; the next frame 0x81 -> pulse with 0x81.
REQ-028 CLKS_PER_BIT=16, frame 0xC3 -> pulse with 0xC3; the line-to-ready delay scales to approximately 9.5 bit times.
